mem_access_unit: RTL
====================

# mem_access_unit

Load/store unit of the MEM stage, on the consuming side of the EX/MEM pipeline register. It decodes `mem_ctrl`/`mem_alu_out`/`mem_store_data` into a request/grant/response transaction on the data-memory bus and formats the store lanes. It sign- or zero-extends load data for the MEM/WB register and holds `lsu_stall` to the hazard unit until the access completes.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255: watchdog limit in cycles, 8-bit; only used with `LSU_TIMEOUT_EN`.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `mem_ctrl`  in  ctrl_t  EX/MEM control; uses `mem_read`, `mem_write`, `mem_funct3[2:0]`.
- `mem_alu_out`  in  32  effective byte address.
- `mem_store_data`  in  32  rs2 value; the low byte/half/word is significant.
- `dmem_req`  out  1  request valid.
- `dmem_we`  out  1  1 = store.
- `dmem_addr`  out  32  word-aligned address, `{addr[31:2],2'b00}`.
- `dmem_be`  out  4  byte enables.
- `dmem_wdata`  out  32  lane-aligned store data.
- `dmem_gnt`  in  1  request accepted this cycle.
- `dmem_rvalid`  in  1  load data valid; arrives no earlier than the cycle after `gnt`.
- `dmem_rdata`  in  32  raw load word.
- `lsu_stall`  out  1  freeze PC through EX/MEM; bubble MEM/WB.
- `load_data`  out  32  extended load result; valid in DONE.
- `lsu_done`  out  1  one-cycle completion pulse.
- `misalign_exc`  out  1  pulse in DONE; misaligned address or illegal funct3.
- `bus_err`  out  1  pulse in DONE on timeout; tied 0 without the macro.

## Operation
- Access = `mem_read | mem_write`. If both are set, the access is a store.
- FSM states:
  - IDLE: on an access, check alignment. Misaligned → DONE with `misalign_exc`. Otherwise → REQ, registering addr, be, wdata and funct3.
  - REQ: `dmem_req`=1 until `dmem_gnt`. On grant, a store → DONE and a load → RESP.
  - RESP: wait for `dmem_rvalid`, then capture the extended data → DONE.
  - DONE: `lsu_done`=1, `lsu_stall`=0 → IDLE. The pipeline advances at the end of DONE.
- Alignment: LH/LHU/SH need `addr[0]`=0. LW/SW need `addr[1:0]`=0. Byte accesses are always aligned.
- funct3 values 011, 110 and 111 are illegal and raise `misalign_exc`. Stores also treat 100 and 101 as illegal.
- Store lanes:
  - SB: `be`=0001<<addr[1:0], `wdata`={4{b}}.
  - SH: `be`=0011<<{addr[1],0}, `wdata`={2{h}}.
  - SW: `be`=1111.
- Loads: select the lane by `addr[1:0]`. LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through. Loads drive `be` as for stores.
- `lsu_stall` = (IDLE & access) | REQ | RESP. It is combinational in IDLE and registered otherwise.
- `load_data` holds its value until the next load capture. It is 0 after stores and errors.

## Timing
- Reset values:
  - state = IDLE.
  - `dmem_req`, `dmem_we`, `lsu_done`, `misalign_exc`, `bus_err` = 0.
  - `dmem_addr`, `dmem_be`, `dmem_wdata`, `load_data` = 0.
- Minimum latency, counting the IDLE cycle:
  - Store: 3 cycles (IDLE, REQ with same-cycle `gnt`, DONE).
  - Load: 4 cycles (IDLE, REQ, RESP, DONE).
  - Misaligned: 2 cycles (IDLE, DONE).
- Each extra cycle of `gnt` or `rvalid` wait adds one cycle.
- `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_be` and `dmem_wdata` are stable from REQ entry until `gnt`. `req` drops in the cycle after `gnt`.
- `rvalid` outside RESP is ignored.
- Reset mid-transaction: → IDLE next edge and `req` drops. The memory shares this reset, so no stale response returns.
- In DONE, the access on the inputs is not re-decoded. After DONE the unit starts from IDLE, so back-to-back accesses cost no extra cycle.

## Configuration
- `LSU_TIMEOUT_EN` defined:
  - An 8-bit counter clears on REQ entry and increments in REQ and RESP.
  - Reaching `TIMEOUT_CYCLES` → DONE with `bus_err`=1, `req`=0 and `load_data`=0.
  - A late `rvalid` for the abandoned access is ignored.
- Undefined: no counter, `bus_err` tied 0, and the unit waits indefinitely.

## Structure
- Additions to `cpu_types`:
  - `lsu_state_t` enum (IDLE, REQ, RESP, DONE).
  - funct3 constants `F3_LB`, `F3_LH`, `F3_LW`, `F3_LBU`, `F3_LHU`.
  - The `ctrl_t` fields `mem_read`, `mem_write`, `mem_funct3`.
- One combinational sub-module, `load_extend`: takes raw word, `addr[1:0]` and funct3; produces the 32-bit extended result.

## Test plan
- SW 0xDEADBEEF @0x100, `gnt` in REQ → be=1111, addr=0x100, `lsu_done` on cycle 3, stall high for cycles 1–2.
- SB 0x000000A5 @0x103 → be=1000, wdata=0xA5A5A5A5; SH @0x102 → be=1100.
- LB @0x101 with rdata 0x0000_8000 → load_data=0xFFFFFF80; LBU at the same address → 0x00000080; LHU @0x102 with rdata 0xBEEF0000 → 0x0000BEEF.
- LW @0x102 → no `req`, `misalign_exc` pulse in cycle 2; funct3=011 gives the same response.
- Load with `gnt` delayed 3 cycles and `rvalid` 2 cycles after → DONE in cycle 8, `req` stable throughout; reset asserted in RESP → IDLE, `req`=0, no `lsu_done`.
- With `LSU_TIMEOUT_EN` and TIMEOUT_CYCLES=4, `gnt` never asserted → `bus_err` pulse, stall released; without the macro, stall stays high.

Source files
------------

// File: rtl/cpu_types.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_types (package)
//  Purpose  : Shared types for the MEM-stage load/store unit. Holds the EX/MEM
//             control struct, the LSU state encoding, load/store funct3
//             constants and the byte-enable / lane-replication helpers.
//  Revision : 1.0  initial release
// ============================================================================
package cpu_types;

    // EX/MEM control fields consumed by the load/store unit
    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic [2:0] mem_funct3;
    } ctrl_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Byte enables depend only on access size (funct3[1:0]) and the low
    // address bits; loads and stores share the same lane pattern.
    function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] lo);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << lo;
            2'b01:   be = 4'b0011 << {lo[1], 1'b0};
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate the significant store bits across every lane so the
    // memory only has to honour the byte enables.
    function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] w;
        case (f3[1:0])
            2'b00:   w = {4{d[7:0]}};
            2'b01:   w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_extend.sv
`default_nettype none
// ============================================================================
//  Module   : load_extend
//  Purpose  : Combinational load formatter. Selects the byte/half lane of the
//             raw memory word and sign- or zero-extends it per funct3.
//  Ports    : raw      in  32  raw word from the data bus
//             addr_lo  in   2  byte offset within the word
//             funct3   in   3  load type (LB/LH/LW/LBU/LHU)
//             ext      out 32  extended result (0 for non-load encodings)
//  Revision : 1.0  initial release
// ============================================================================
module load_extend
    import cpu_types::*;
(
    input  logic [31:0] raw,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] ext
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = raw[{addr_lo, 3'b000} +: 8];
        w_half = addr_lo[1] ? raw[31:16] : raw[15:0];
        case (funct3)
            F3_LB:   ext = {{24{w_byte[7]}}, w_byte};
            F3_LH:   ext = {{16{w_half[15]}}, w_half};
            F3_LW:   ext = raw;
            F3_LBU:  ext = {24'd0, w_byte};
            F3_LHU:  ext = {16'd0, w_half};
            default: ext = 32'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_unit
//  Purpose  : MEM-stage load/store unit. Turns the EX/MEM access into a
//             req/gnt/rvalid data-bus transaction, formats store lanes,
//             extends load data and stalls the pipeline until completion.
//  Ports    : clk, reset (sync, active-high)
//             mem_ctrl / mem_alu_out / mem_store_data   EX/MEM inputs
//             dmem_req/we/addr/be/wdata   out  bus request
//             dmem_gnt/rvalid/rdata       in   bus grant and response
//             lsu_stall, lsu_done, load_data, misalign_exc, bus_err   out
//  Config   : define LSU_TIMEOUT_EN to enable the TIMEOUT_CYCLES watchdog
//             (bus_err); otherwise bus_err is 0 and the unit waits forever.
//  Revision : 1.0  initial release
// ============================================================================
module mem_access_unit
    import cpu_types::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  ctrl_t       mem_ctrl,
    input  logic [31:0] mem_alu_out,
    input  logic [31:0] mem_store_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        lsu_stall,
    output logic [31:0] load_data,
    output logic        lsu_done,
    output logic        misalign_exc,
    output logic        bus_err
);

    lsu_state_t  r_state, w_next_state;
    logic        r_we;
    logic [31:0] r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [1:0]  r_addr_lo;
    logic [2:0]  r_funct3;
    logic [31:0] r_load_data;
    logic        r_misalign;

    logic        w_access;
    logic        w_is_store;
    logic        w_illegal;
    logic        w_misalign;
    logic        w_timeout;
    logic [31:0] w_ext;

    // ---------------- IDLE-cycle decode of the EX/MEM access ----------------
    always_comb begin
        w_access   = mem_ctrl.mem_read | mem_ctrl.mem_write;
        w_is_store = mem_ctrl.mem_write;      // write wins when both are set
        w_illegal  = (mem_ctrl.mem_funct3 == 3'b011) ||
                     (mem_ctrl.mem_funct3 == 3'b110) ||
                     (mem_ctrl.mem_funct3 == 3'b111) ||
                     (w_is_store && mem_ctrl.mem_funct3[2]);
        w_misalign = w_illegal ||
                     ((mem_ctrl.mem_funct3[1:0] == 2'b01) && mem_alu_out[0]) ||
                     ((mem_ctrl.mem_funct3[1:0] == 2'b10) && (mem_alu_out[1:0] != 2'b00));
    end

    load_extend u_load_extend (
        .raw     (dmem_rdata),
        .addr_lo (r_addr_lo),
        .funct3  (r_funct3),
        .ext     (w_ext)
    );

    // ---------------- optional watchdog ----------------
`ifdef LSU_TIMEOUT_EN
    localparam logic [7:0] c_timeout_last = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] r_timer;
    logic       r_bus_err;

    // Cleared while idle, so it is zero on REQ entry; counts every REQ/RESP
    // cycle. The last permitted wait cycle is TIMEOUT_CYCLES-1.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_timer <= 8'd0;
        end else if ((r_state == REQ) || (r_state == RESP)) begin
            r_timer <= r_timer + 8'd1;
        end else begin
            r_timer <= 8'd0;
        end
    end

    assign w_timeout = ((r_state == REQ) || (r_state == RESP)) && (r_timer == c_timeout_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bus_err <= 1'b0;
        end else if (r_state == REQ) begin
            r_bus_err <= !dmem_gnt && w_timeout;
        end else if (r_state == RESP) begin
            r_bus_err <= !dmem_rvalid && w_timeout;
        end else if (r_state == IDLE) begin
            r_bus_err <= 1'b0;
        end
    end

    assign bus_err = (r_state == DONE) && r_bus_err;
`else
    assign w_timeout = 1'b0;
    assign bus_err   = 1'b0;
`endif

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_access) begin
                    w_next_state = w_misalign ? DONE : REQ;
                end
            end
            REQ: begin
                if (dmem_gnt) begin
                    w_next_state = r_we ? DONE : RESP;
                end else if (w_timeout) begin
                    w_next_state = DONE;
                end
            end
            RESP: begin
                if (dmem_rvalid || w_timeout) begin
                    w_next_state = DONE;
                end
            end
            default: w_next_state = IDLE;   // DONE: pipeline advances now
        endcase
    end

    // ---------------- request / result registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_we        <= 1'b0;
            r_addr      <= 32'd0;
            r_be        <= 4'd0;
            r_wdata     <= 32'd0;
            r_addr_lo   <= 2'd0;
            r_funct3    <= 3'd0;
            r_load_data <= 32'd0;
            r_misalign  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_access) begin
                        r_misalign <= w_misalign;
                        if (w_misalign) begin
                            r_load_data <= 32'd0;
                        end else begin
                            r_we      <= w_is_store;
                            r_addr    <= {mem_alu_out[31:2], 2'b00};
                            r_be      <= lane_be(mem_ctrl.mem_funct3, mem_alu_out[1:0]);
                            r_wdata   <= lane_wdata(mem_ctrl.mem_funct3, mem_store_data);
                            r_addr_lo <= mem_alu_out[1:0];
                            r_funct3  <= mem_ctrl.mem_funct3;
                        end
                    end
                end
                REQ: begin
                    // Completed stores and abandoned requests both clear the result
                    if ((dmem_gnt && r_we) || (!dmem_gnt && w_timeout)) begin
                        r_load_data <= 32'd0;
                    end
                end
                RESP: begin
                    if (dmem_rvalid) begin
                        r_load_data <= w_ext;
                    end else if (w_timeout) begin
                        r_load_data <= 32'd0;
                    end
                end
                default: r_misalign <= 1'b0;
            endcase
        end
    end

    // ---------------- outputs ----------------
    assign dmem_req     = (r_state == REQ);
    assign dmem_we      = r_we;
    assign dmem_addr    = r_addr;
    assign dmem_be      = r_be;
    assign dmem_wdata   = r_wdata;
    assign load_data    = r_load_data;
    assign lsu_done     = (r_state == DONE);
    assign misalign_exc = (r_state == DONE) && r_misalign;
    // The IDLE term is combinational so the access stalls in its first cycle
    assign lsu_stall    = ((r_state == IDLE) && w_access) ||
                          (r_state == REQ) || (r_state == RESP);

endmodule
`default_nettype wire
